mips_multicycle_control: RTL
============================

# mips_multicycle_control

Main control FSM for the multi-cycle MIPS core. It runs each instruction through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath mux selects, the write enables, the memory handshake and the 3-bit `alu_op` class code consumed by `alu_control`. It sits between the instruction register opcode field and the shared ALU, register file, PC and unified memory port.

## Interface
No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  IR[31:26]; held stable by the datapath from DECODE to instruction end
- `zero`  in  1  ALU zero flag
- `mem_ready`  in  1  memory completes the current access this cycle
- `mem_req`  out  1  memory access request
- `mem_we`  out  1  write access (valid only with `mem_req`)
- `i_or_d`  out  1  address select: 0 = PC, 1 = ALUOut
- `ir_write`  out  1  load IR
- `pc_en`  out  1  PC load enable
- `pc_src`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `alu_src_a`  out  1  0 = PC, 1 = reg A
- `alu_src_b`  out  2  00 = reg B, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm<<2
- `alu_op`  out  3  000 = opcode decode, 001 = funct decode, 010 = subtract, 100 = add
- `reg_write`  out  1  register file write enable
- `reg_dst`  out  1  0 = rt, 1 = rd
- `mem_to_reg`  out  1  0 = ALUOut, 1 = MDR
- `instr_done`  out  1  one-cycle pulse in the final cycle of each instruction
- `illegal`  out  1  sticky flag: unsupported opcode seen
- `state`  out  4  current state (debug)

## Operation
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, RTWB=7, BRANCH=8, ITEX=9, ITWB=10, JUMP=11.
- Any output not listed for a state is 0, including `alu_op` = 000.
- FETCH:
  - Drives mem_req=1, i_or_d=0, src_a=0, src_b=01, alu_op=100, pc_src=00.
  - ir_write = pc_en = mem_ready.
  - Stays in FETCH while !mem_ready; goes to DECODE when mem_ready.
- DECODE:
  - Drives src_a=0, src_b=11, alu_op=100 (branch target into ALUOut).
  - Next state by opcode:
    - 000000 goes to RTEX.
    - 100011 (lw) and 101011 (sw) go to MEMADR.
    - 000100 (beq) and 000101 (bne) go to BRANCH.
    - 000010 (j) goes to JUMP.
    - 001000, 001100, 001101, 001010, 001110 go to ITEX.
    - Any other opcode goes to FETCH, sets `illegal`, and pulses instr_done.
- MEMADR: src_a=1, src_b=10, alu_op=100. lw goes to MEMRD; sw goes to MEMWR.
- MEMRD: mem_req=1, i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1, instr_done=1. Goes to FETCH.
- MEMWR: mem_req=1, mem_we=1, i_or_d=1. Waits for mem_ready; on the ready cycle instr_done=1 and next state is FETCH.
- RTEX: src_a=1, src_b=00, alu_op=001. Goes to RTWB.
- RTWB: reg_write=1, reg_dst=1, mem_to_reg=0, instr_done=1. Goes to FETCH.
- BRANCH:
  - Drives src_a=1, src_b=00, alu_op=010, pc_src=01, instr_done=1.
  - pc_en = zero for beq and !zero for bne.
  - Goes to FETCH.
- ITEX: src_a=1, src_b=10, alu_op=000 (alu_control resolves the op from opcode). Goes to ITWB.
- ITWB: reg_write=1, reg_dst=0, mem_to_reg=0, instr_done=1. Goes to FETCH.
- JUMP: pc_src=10, pc_en=1, instr_done=1. Goes to FETCH.
- Encodings 12–15 are unreachable; if entered, next state is FETCH with no outputs asserted.
- `illegal` stays set until rst.

## Timing
- Outputs are Moore (decoded from registered `state`) except:
  - ir_write and pc_en in FETCH, which depend combinationally on mem_ready;
  - pc_en in BRANCH, which depends on zero;
  - instr_done in MEMWR, which depends on mem_ready.
- Reset:
  - At the edge with rst=1, state becomes FETCH and illegal becomes 0.
  - While rst=1, mem_req, mem_we, ir_write, pc_en, reg_write and instr_done are forced to 0, regardless of state.
  - A reset mid-instruction abandons that instruction; no further writes occur.
- Latency with zero-wait memory:
  - R-type: 4 cycles
  - I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - j: 3 cycles
  - illegal: 2 cycles
- Each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. mem_req stays high and all other outputs stay constant during the wait.
- mem_ready is ignored in states that do not assert mem_req.

## Test plan
- Reset: hold rst for 2 cycles with mem_ready=1 → state=0, all write enables 0. After release: FETCH asserts mem_req, ir_write=1, pc_en=1.
- R-type with zero-wait memory: opcode=000000 → state sequence 0,1,6,7,0. alu_op=001 in RTEX. reg_write=1 and reg_dst=1 only in RTWB. One instr_done pulse.
- lw with 2 wait cycles in MEMRD: opcode=100011, mem_ready low for 2 cycles → sequence 0,1,2,3,3,3,4,0 (8 cycles). mem_req held throughout MEMRD. mem_to_reg=1 in MEMWB.
- Branches:
  - beq with zero=1 → pc_en=1, pc_src=01 in BRANCH.
  - beq with zero=0 → pc_en=0.
  - bne with zero=0 → pc_en=1.
- Immediate and jump:
  - addi (001000) → alu_op=000, src_b=10 in ITEX; reg_write in ITWB.
  - j → pc_src=10, pc_en=1 in the third cycle.
- Illegal opcode and mid-instruction reset:
  - opcode=111111 → DECODE goes to FETCH, illegal=1 stays set.
  - rst asserted during MEMWR → no mem_we at that edge, state=0, illegal=0.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
//   Main control FSM for the multi-cycle MIPS core. Each instruction is walked
//   through fetch / decode / execute / memory / writeback. The FSM drives the
//   datapath mux selects, write enables, the unified memory handshake and the
//   3-bit ALU class code consumed by alu_control.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   opcode            IR[31:26], stable from DECODE to instruction end
//   zero              ALU zero flag (branch resolution)
//   mem_ready         memory completes the current access this cycle
//   mem_req/mem_we    memory request / write qualifier
//   i_or_d            memory address select (0 = PC, 1 = ALUOut)
//   ir_write, pc_en   IR load, PC load
//   pc_src            00 = ALU result, 01 = ALUOut, 10 = jump target
//   alu_src_a/_b      ALU operand selects
//   alu_op            000 opcode, 001 funct, 010 subtract, 100 add
//   reg_write/reg_dst/mem_to_reg   register file write controls
//   instr_done        pulse in the final cycle of each instruction
//   illegal           sticky unsupported-opcode flag
//   state             current state (debug)
module mips_multicycle_control (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       i_or_d,
  output logic       ir_write,
  output logic       pc_en,
  output logic [1:0] pc_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTEX   = 4'd6,
    S_RTWB   = 4'd7,
    S_BRANCH = 4'd8,
    S_ITEX   = 4'd9,
    S_ITWB   = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_XORI  = 6'b001110;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_en      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = 3'b000;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    instr_done = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = 3'b100;
        ir_write  = mem_ready;
        pc_en     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        alu_op    = 3'b100;
        case (opcode)
          OP_RTYPE:                state_d = S_RTEX;
          OP_LW, OP_SW:            state_d = S_MEMADR;
          OP_BEQ, OP_BNE:          state_d = S_BRANCH;
          OP_J:                    state_d = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI,
          OP_SLTI, OP_XORI:        state_d = S_ITEX;
          default: begin
            state_d    = S_FETCH;
            illegal_d  = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 3'b100;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req    = 1'b1;
        mem_we     = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = S_FETCH;
      end
      S_RTEX: begin
        alu_src_a = 1'b1;
        alu_op    = 3'b001;
        state_d   = S_RTWB;
      end
      S_RTWB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 3'b010;
        pc_src     = 2'b01;
        instr_done = 1'b1;
        // opcode[0] separates bne (taken on !zero) from beq (taken on zero).
        pc_en      = opcode[0] ? ~zero : zero;
        state_d    = S_FETCH;
      end
      S_ITEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ITWB;
      end
      S_ITWB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset suppresses every side effect, whatever the current state.
    if (rst) begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      ir_write   = 1'b0;
      pc_en      = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign illegal = illegal_q;
  assign state   = state_q;

endmodule
